adder_word_seq: RTL and testbench
=================================

// Module: adder_word_seq
// PURPOSE
//  Multi-cycle add/subtract sequencer around one adder_n slice of width N.
//  Adds or subtracts two N*WORDS-bit operands by driving the slice once per cycle,
//  low word first, with the slice carry-out fed back as the next cycle's Cin.
//  Trades latency for area in the DSP datapath; used where wide accumulators
//  cannot afford a full-width ripple chain.
// PARAMETERS
//  N      8  width of the single adder_n slice instantiated inside
//  WORDS  4  number of slices per operand; total width W = N*WORDS (WORDS >= 2)
// PORTS
//  clk    in   1  rising-edge clock
//  rst_n  in   1  synchronous active-low reset
//  start  in   1  request; accepted only when ready=1
//  sub    in   1  sampled with start: 0 = A+B, 1 = A-B
//  A      in   W  operand A, sampled on accept
//  B      in   W  operand B, sampled on accept
//  ready  out  1  block can accept start (state IDLE or DONE)
//  busy   out  1  state RUN
//  done   out  1  one-cycle pulse: Sum/Cout/Ovf valid
//  Sum    out  W  result; held until the next accept
//  Cout   out  1  final carry; for sub, 1 = no borrow (A >= B unsigned)
//  Ovf    out  1  two's-complement signed overflow of the W-bit result
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; idx=0; carry reg=0; Sum=0; Cout=0;
//    Ovf=0; done=0; ready=1; busy=0. Reset in RUN aborts; no done is produced.
//  - FSM IDLE -> RUN on start; RUN -> DONE after slice WORDS-1; DONE -> IDLE, or
//    DONE -> RUN when start=1 in DONE (back-to-back accept, no bubble).
//  - Accept: latch A, B' = sub ? ~B : B, cin_reg = sub, idx = 0, clear Sum.
//  - RUN cycle k (idx=k): slice inputs A[k*N+:N], B'[k*N+:N], Cin=cin_reg;
//    Sum[k*N+:N] <= slice Sum; cin_reg <= slice Cout; idx <= idx+1.
//  - On the last slice (idx=WORDS-1) also register: Cout <= slice Cout;
//    Ovf <= (A[W-1] == B'[W-1]) && (slice Sum[N-1] != A[W-1]).
//  - done=1 exactly in the DONE state. With accept at edge t, done is high in the
//    cycle after edge t+WORDS; latency = WORDS+1 cycles from accept to done.
//  - start while busy=1 is ignored (not queued); A/B/sub changes in RUN have no effect.
//  - idx saturates by FSM exit; idx is never used outside 0..WORDS-1.
//  - Result arithmetic is modulo 2^W; sub uses ~B + 1 via Cin=1 on slice 0.
//  - Sum bits of unfinished slices read 0 during RUN (cleared on accept).
// TESTING (N=8, WORDS=4)
//  T1 A=FFFFFFFF B=00000001 sub=0 -> done 5 cycles after accept, Sum=00000000, Cout=1, Ovf=0
//  T2 A=00000005 B=00000007 sub=1 -> Sum=FFFFFFFE, Cout=0 (borrow), Ovf=0; A=7,B=5 -> Sum=2, Cout=1
//  T3 A=7FFFFFFF B=00000001 sub=0 -> Sum=80000000, Ovf=1; A=80000000 B=1 sub=1 -> Sum=7FFFFFFF, Ovf=1
//  T4 start pulsed again during RUN with other operands -> ignored; result is the first op only
//  T5 rst_n=0 for one cycle mid-RUN (idx=2) -> next cycle Sum=0, ready=1, no done pulse follows
//  T6 start held in DONE with new operands -> next op runs with no idle cycle; two done pulses 5 cycles apart

Source files
------------

// File: rtl/adder_word_seq.sv
// Multi-cycle word-serial add/subtract: one N-bit adder_n slice is reused once per
// word, low word first, with the slice carry-out looped back as the next carry-in.

module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum  = full[N-1:0];
    assign cout = full[N];
endmodule

module adder_word_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] Sum,
    output logic               Cout,
    output logic               Ovf
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               cin_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [N-1:0]       sl_a;
    logic [N-1:0]       sl_b;
    logic [N-1:0]       sl_sum;
    logic               sl_cout;
    logic               last;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign sl_a = a_reg[idx*N +: N];
    assign sl_b = b_reg[idx*N +: N];
    assign last = (idx == IDX_W'(WORDS - 1));

    adder_n #(.N(N)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (cin_reg),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // b_reg already holds ~B for subtraction, so the sign test uses the inverted MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cin_reg <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= sub ? ~B : B;
                        cin_reg <= sub;
                        idx     <= '0;
                        Sum     <= '0;
                        state   <= RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    Sum[idx*N +: N] <= sl_sum;
                    cin_reg         <= sl_cout;
                    if (last) begin
                        Cout  <= sl_cout;
                        Ovf   <= signed_ovf(a_reg[W-1], b_reg[W-1], sl_sum[N-1]);
                        state <= DONE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_word_seq.sv
// Scoreboard bench for adder_word_seq (N=8, WORDS=4): directed vectors with
// hand-computed results, checked by an independent done-driven monitor.

module tb_adder_word_seq;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         ready, busy, done, Cout, Ovf;
    logic [W-1:0] Sum;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   done_cycs[$];

    adder_word_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", Sum, e.sum);
                chk("cout", W'(Cout), W'(e.cout));
                chk("ovf", W'(Ovf), W'(e.ovf));
                chk("done_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    // Waits for ready at a falling edge, then presents one request for the next rising edge
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        A = a;
        B = b;
        sub = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int ac;
        exp_t e;
        accept(a, b, s, ac);
        e.sum = es;
        e.cout = ec;
        e.ovf = eo;
        e.cyc = ac + WORDS;
        sb.push_back(e);
    endtask

    initial begin
        int ac;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_sum", Sum, 32'h0);
        chk("rst_cout", W'(Cout), W'(0));
        chk("rst_ovf", W'(Ovf), W'(0));
        rst_n = 1'b1;

        // T1 carry ripples through every word
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        repeat (8) @(posedge clk);

        // T2 subtract with and without borrow
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        repeat (7) @(posedge clk);

        // T3 signed overflow both directions; Sum clears on accept
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk);
        chk("sum_cleared_run", Sum, 32'h0);
        chk("busy_in_run", W'(busy), W'(1));
        chk("ready_in_run", W'(ready), W'(0));
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        repeat (7) @(posedge clk);

        // T4 start during RUN is ignored, operands changing mid-run have no effect
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        @(negedge clk);
        A = 32'hFFFF_FFFF;
        B = 32'hFFFF_FFFF;
        sub = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);

        // T5 reset mid-run at idx=2 aborts with no done
        accept(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, ac);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sum", Sum, 32'h0);
        chk("abort_ready", W'(ready), W'(1));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // T6 back-to-back accept from DONE
        done_cycs.delete();
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        issue(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (done_cycs.size() >= 2) begin
            chk("b2b_spacing", W'(done_cycs[1] - done_cycs[0]), W'(WORDS + 1));
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_count: got %0d done pulses expected at least 2", done_cycs.size());
        end
        chk("final_ready", W'(ready), W'(1));
        chk("final_done", W'(done), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
